instr_decode_stage: RTL and testbench

- Pipeline stage between instruction fetch and the sign_extend / register-file read stage of the 16-bit processor.
- Accepts 16-bit instructions with their PC over a valid/ready handshake and decodes fields and control signals into an output register.
- Presents the 5-bit immediate field (d_imm5) that drives sign_extend's d_in.
- Contains a one-entry skid buffer so full throughput holds under downstream back-pressure; supports a synchronous pipeline flush.

---
 rtl/instr_decode_stage.sv | 132 +++++++++++++
 tb/tb_instr_decode_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - instruction decode stage with one-entry skid buffer
// Decodes 16-bit instructions into a registered field/control bundle; valid/ready in and out.
module instr_decode_stage #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [3:0]         d_opcode,
   output logic [2:0]         d_rd,
   output logic [2:0]         d_rs1,
   output logic [2:0]         d_rs2,
   output logic [2:0]         d_funct,
   output logic [4:0]         d_imm5,
   output logic               d_is_imm,
   output logic               d_reg_we,
   output logic               d_mem_rd,
   output logic               d_mem_wr,
   output logic               d_branch,
   output logic               d_illegal
);

   typedef struct packed {
      logic [3:0] opcode;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [2:0] funct;
      logic [4:0] imm5;
      logic       is_imm;
      logic       reg_we;
      logic       mem_rd;
      logic       mem_wr;
      logic       branch;
      logic       illegal;
   } dec_t;

   function automatic dec_t decode(input logic [INSTR_W-1:0] instr);
      dec_t d;
      d        = '0;
      d.opcode = instr[15:12];
      d.rd     = instr[11:9];
      d.rs1    = instr[8:6];
      if (instr[15:12] == 4'h0) begin
         d.rs2   = instr[5:3];
         d.funct = instr[2:0];
      end else begin
         d.imm5  = instr[4:0];
      end
      case (instr[15:12])
         4'h0:             d.reg_we = 1'b1;
         4'h1, 4'h2, 4'h3: begin d.is_imm = 1'b1; d.reg_we = 1'b1; end
         4'h4:             begin d.is_imm = 1'b1; d.reg_we = 1'b1; d.mem_rd = 1'b1; end
         4'h5:             begin d.is_imm = 1'b1; d.mem_wr = 1'b1; end
         4'h6, 4'h7:       begin d.is_imm = 1'b1; d.branch = 1'b1; end
         4'hF:             d.illegal = 1'b0;
         default:          d.illegal = 1'b1;
      endcase
      return d;
   endfunction

   logic               skid_valid;
   logic [INSTR_W-1:0] skid_instr;
   logic [PC_W-1:0]    skid_pc;
   dec_t               dec_q;
   dec_t               dec_src;
   logic [PC_W-1:0]    src_pc;
   logic               accept;
   logic               out_load;

   // in_ready is a flop that mirrors skid emptiness, so out_ready never reaches it combinationally
   always_comb begin
      accept   = in_valid & in_ready;
      out_load = ~out_valid | out_ready;
      dec_src  = decode(skid_valid ? skid_instr : in_instr);
      src_pc   = skid_valid ? skid_pc : in_pc;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         dec_q      <= '0;
         out_pc     <= '0;
         skid_valid <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
         in_ready   <= 1'b1;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else if (out_load) begin
         // skid entry, when present, always drains before any new input
         if (skid_valid || accept) begin
            out_valid <= 1'b1;
            dec_q     <= dec_src;
            out_pc    <= src_pc;
         end else begin
            out_valid <= 1'b0;
         end
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_instr <= in_instr;
         skid_pc    <= in_pc;
         in_ready   <= 1'b0;
      end
   end

   assign d_opcode  = dec_q.opcode;
   assign d_rd      = dec_q.rd;
   assign d_rs1     = dec_q.rs1;
   assign d_rs2     = dec_q.rs2;
   assign d_funct   = dec_q.funct;
   assign d_imm5    = dec_q.imm5;
   assign d_is_imm  = dec_q.is_imm;
   assign d_reg_we  = dec_q.reg_we;
   assign d_mem_rd  = dec_q.mem_rd;
   assign d_mem_wr  = dec_q.mem_wr;
   assign d_branch  = dec_q.branch;
   assign d_illegal = dec_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - self-checking bench for instr_decode_stage
// Queue model of held instructions plus a decode table; directed steps then random traffic.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [15:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_pc;
   logic [3:0]  d_opcode;
   logic [2:0]  d_rd, d_rs1, d_rs2, d_funct;
   logic [4:0]  d_imm5;
   logic        d_is_imm, d_reg_we, d_mem_rd, d_mem_wr, d_branch, d_illegal;

   int vectors    = 0;
   int miscompares = 0;
   logic [31:0] q[$];

   instr_decode_stage #(.PC_W(16), .INSTR_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .d_opcode(d_opcode), .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_funct(d_funct),
      .d_imm5(d_imm5), .d_is_imm(d_is_imm), .d_reg_we(d_reg_we), .d_mem_rd(d_mem_rd),
      .d_mem_wr(d_mem_wr), .d_branch(d_branch), .d_illegal(d_illegal)
   );

   always #5 clk = ~clk;

   // {is_imm, reg_we, mem_rd, mem_wr, branch, illegal}
   function automatic logic [5:0] ctrl_ref(input logic [3:0] op);
      case (op)
         4'h0:             return 6'b010000;
         4'h1, 4'h2, 4'h3: return 6'b110000;
         4'h4:             return 6'b111000;
         4'h5:             return 6'b100100;
         4'h6, 4'h7:       return 6'b100010;
         4'hF:             return 6'b000000;
         default:          return 6'b000001;
      endcase
   endfunction

   function automatic logic [63:0] exp_vec(input logic [31:0] e);
      logic [15:0] ins;
      logic        r;
      ins = e[15:0];
      r   = (ins[15:12] == 4'h0);
      return {21'b0, e[31:16], ins[15:12], ins[11:9], ins[8:6],
              r ? ins[5:3] : 3'b0, r ? ins[2:0] : 3'b0, r ? 5'b0 : ins[4:0], ctrl_ref(ins[15:12])};
   endfunction

   function automatic logic [63:0] obs_vec();
      return {21'b0, out_pc, d_opcode, d_rd, d_rs1, d_rs2, d_funct, d_imm5,
              d_is_imm, d_reg_we, d_mem_rd, d_mem_wr, d_branch, d_illegal};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      chk("out_valid", {63'b0, out_valid}, {63'b0, q.size() > 0});
      chk("in_ready", {63'b0, in_ready}, {63'b0, q.size() < 2});
      if (q.size() > 0) chk("decode", obs_vec(), exp_vec(q[0]));
   endtask

   task automatic step();
      bit fi, fo;
      fi = rst_n && !flush && in_valid && in_ready;
      fo = rst_n && !flush && out_valid && out_ready;
      @(posedge clk);
      #1;
      if (!rst_n || flush) q.delete();
      else begin
         if (fo && q.size() > 0) void'(q.pop_front());
         if (fi) q.push_back({in_pc, in_instr});
      end
      check_state();
   endtask

   task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc);
      in_valid = v;
      in_instr = ins;
      in_pc    = pc;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b1, 16'h145D, 16'h0010);

      // reset held two cycles with a valid instruction presented
      step();
      step();
      chk("reset_fields", obs_vec(), 64'h0);
      rst_n = 1'b1;

      // ADDI r2,r1,-3
      step();
      drive(1'b0, 16'h0000, 16'h0000);
      chk("addi_imm5", {59'b0, d_imm5}, 64'h1D);
      chk("addi_sext", {48'b0, {11{d_imm5[4]}}, d_imm5}, 64'hFFFD);
      step();

      // back-to-back stream
      drive(1'b1, 16'h0650, 16'h0020); step();
      chk("add_rs2", {61'b0, d_rs2}, 64'h2);
      drive(1'b1, 16'h4A45, 16'h0022); step();
      drive(1'b1, 16'h5A45, 16'h0024); step();
      drive(1'b0, 16'h0000, 16'h0000); step();
      step();

      // back-pressure: output register, skid, then stalled third
      out_ready = 1'b0;
      drive(1'b1, 16'h1111, 16'h0100); step();
      drive(1'b1, 16'h2222, 16'h0102); step();
      drive(1'b1, 16'h3333, 16'h0104); step();
      step();
      chk("stall_q_depth", {32'b0, q.size()}, 64'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      drive(1'b0, 16'h0000, 16'h0000);
      step(); step();

      // flush with output and skid full, plus an incoming instruction
      out_ready = 1'b0;
      drive(1'b1, 16'h4444, 16'h0200); step();
      drive(1'b1, 16'h5555, 16'h0202); step();
      drive(1'b1, 16'h6666, 16'h0204); flush = 1'b1; step();
      flush = 1'b0; drive(1'b0, 16'h0000, 16'h0000); out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();

      // illegal and NOP
      drive(1'b1, 16'h9000, 16'h0300); step();
      chk("illegal_ctrl", {58'b0, d_is_imm, d_reg_we, d_mem_rd, d_mem_wr, d_branch, d_illegal}, 64'h1);
      drive(1'b1, 16'hF000, 16'h0302); step();
      chk("nop_ctrl", {58'b0, d_is_imm, d_reg_we, d_mem_rd, d_mem_wr, d_branch, d_illegal}, 64'h0);
      drive(1'b0, 16'h0000, 16'h0000); step();

      // random traffic with occasional flush and reset
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 4) != 0, 16'($urandom), 16'($urandom));
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 40) == 0;
         rst_n     = ($urandom % 300) != 0;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
